text_scheduler: RTL and testbench
=================================

// Module: text_scheduler
// PURPOSE
//  Owns the single-port text RAM (1 cell = {color[1:0], char[5:0]}). Shares it between two users:
//   - the display fetch, which has fixed priority slots;
//   - a host write channel (valid/ready) plus a hardware clear engine.
//  Feeds char/color to the glyph/colour stage, cycle-aligned with the pixel coordinates from the timing generator.
// PARAMETERS
//  COLS     80    text columns (8 px each)
//  ROWS     60    text rows (8 lines each)
//  H_ACTIVE 640   visible pixels per line
//  H_TOTAL  800   pixels per line, including blanking
//  V_ACTIVE 480   visible lines
//  V_TOTAL  525   lines per frame
//  ADDR_W   13    RAM address width; COLS*ROWS must be <= 2**ADDR_W
// PORTS
//  i_clk        in   1       pixel clock
//  i_rst        in   1       synchronous reset, active-high
//  i_x, i_y     in   11 each pixel counters from timing gen (0..H_TOTAL-1, 0..V_TOTAL-1)
//  i_wr_valid   in   1       host write request
//  i_wr_addr    in   ADDR_W  host cell address
//  i_wr_data    in   8       host cell value
//  o_wr_ready   out  1       host write accepted this cycle when valid&ready
//  i_clr        in   1       single-cycle pulse: start clear
//  i_clr_data   in   8       fill value, sampled on the accepted i_clr
//  o_busy       out  1       clear in progress
//  o_ram_addr   out  ADDR_W  RAM address (combinational mux)
//  o_ram_we     out  1       RAM write enable
//  o_ram_wdata  out  8       RAM write data
//  i_ram_rdata  in   8       RAM read data; valid the cycle after the address
//  o_char       out  6       glyph index for the current pixel (registered)
//  o_color      out  2       colour scheme for the current pixel (registered)
// BEHAVIOUR
//  Reset values:
//   - o_char=0, o_color=2'b11, o_busy=0, o_ram_we=0.
//   - FSM=IDLE; row_base=0; fill and clear-address registers=0.
//  Display slot (RAM read, we=0): asserted when either
//   (a) i_y<V_ACTIVE, i_x<H_ACTIVE-8, i_x[2:0]==6 -> addr = row_base + (i_x>>3) + 1;
//   (b) i_x==H_TOTAL-2 and yn<V_ACTIVE, where yn = (i_y==V_TOTAL-1) ? 0 : i_y+1
//       -> addr = rbn, where rbn = (yn==0) ? 0 : (yn[2:0]==0 ? row_base+COLS : row_base).
//  row_base update: row_base<=rbn at the edge ending i_x==H_TOTAL-2. No multiplier is used.
//  Load: i_ram_rdata enters {o_color,o_char} at the edge ending the cycle after a display slot.
//   - The new cell therefore appears on the first pixel of its cell (x[2:0]==0); net latency is 0 vs i_x.
//  Blank: at the edge ending i_x==H_ACTIVE-1, outputs load {2'b11, 6'd0}.
//   - Outputs hold that value through blanking until the slot-(b) load; lines with yn>=V_ACTIVE stay blank.
//  Non-display cycles go to the clear engine if busy, else to the host.
//   - o_wr_ready = !o_busy && !display_slot. This is combinational; it does not depend on i_wr_valid.
//   - Host accept: we=1, addr/wdata from the host.
//   - i_wr_addr >= COLS*ROWS is accepted (ready=1) but dropped (we=0).
//  Clear FSM:
//   - IDLE -> CLEAR on i_clr: latch i_clr_data, clear address=0, o_busy=1 from the next cycle.
//   - In CLEAR, each non-display cycle writes the fill value at the clear address, then increments it.
//   - After the write to COLS*ROWS-1: -> IDLE, o_busy=0 the next cycle.
//   - i_clr while busy is ignored.
//   - Display slots keep priority during a clear; the screen may show a partial clear.
//  Simultaneous i_clr and i_wr_valid in IDLE: the host write is accepted first if the cycle is free. Clear starts next cycle.
//  Reset mid-clear: immediate return to IDLE. RAM is left partially filled and no further writes are issued.
// STRUCTURE
//  text_pkg:
//   - typedef struct packed {logic [1:0] color; logic [5:0] glyph;} cell_t;
//   - state enum {S_IDLE, S_CLEAR};
//   - CELL_BLANK = '{2'b11, 6'd0}.
//  One sub-module, text_slot_gen: slot decode, next-row computation and the row_base register. It outputs disp_slot and disp_addr.
//  Arbitration mux, clear FSM and output registers stay in text_scheduler.
// TESTING
//  Line 0 fetch:
//   - Stimulus: i_x==798 on the last frame line; RAM cell 0=0x85, cell 1=0x2A.
//   - Required: o_char=5/o_color=2 during x=0..7, then o_char=0x2A/o_color=0 during x=8..15. o_ram_addr=1 at x=6.
//  Row advance:
//   - Stimulus: y=7->8.
//   - Required: prefetch addr=80 at x=798. At y=15->16 addr=160. Addresses issued for y=1..7 stay in 0..79.
//  Blanking:
//   - Required: x>=640 gives o_char=0/o_color=3, with no reads after column 79 (no addr 80 on row 0).
//   - Required: lines 480..524 never assert a display read.
//  Host arbitration:
//   - Stimulus: hold i_wr_valid during a full line.
//   - Required: ready=0 exactly at x%8==6 (x<632) and at x=798. Every other cycle gives we=1.
//   - Required: a write to addr 5000 is acknowledged with we=0.
//  Clear:
//   - Stimulus: i_clr with data 0x3F.
//   - Required: busy holds until 4800 writes complete, ready=0 throughout, all cells read back 0x3F.
//   - Stimulus: i_clr again mid-clear. Required: ignored.
//  Reset mid-clear:
//   - Stimulus: i_rst asserted after 100 writes.
//   - Required: busy=0 and we=0 next cycle, cells 100+ unchanged, outputs {3,0}.

Source files
------------

// File: rtl/text_pkg.sv
// Shared types and geometry for the text-mode scheduler: cell layout, clear FSM states
// and screen timing constants.
package text_pkg;

  localparam int COLS     = 80;
  localparam int ROWS     = 60;
  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int ADDR_W   = 13;
  localparam int CELLS    = COLS * ROWS;

  typedef struct packed {
    logic [1:0] color;
    logic [5:0] glyph;
  } cell_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam cell_t CELL_BLANK = '{color: 2'b11, glyph: 6'd0};
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

endpackage

// File: rtl/text_scheduler_if.sv
// Host-facing channel of the text scheduler: cell writes (valid/ready) and the clear engine.
interface text_scheduler_if;
  import text_pkg::*;

  logic              i_wr_valid;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [7:0]        i_wr_data;
  logic              o_wr_ready;
  logic              i_clr;
  logic [7:0]        i_clr_data;
  logic              o_busy;

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_clr, i_clr_data,
    input  o_wr_ready, o_busy
  );

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_clr, i_clr_data,
    output o_wr_ready, o_busy
  );

endinterface

// File: rtl/text_slot_gen.sv
// Display fetch slot decode and per-line row base tracking for the text RAM.
module text_slot_gen
  import text_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [10:0]       x_i,
  input  logic [10:0]       y_i,
  output logic              disp_slot_o,
  output logic [ADDR_W-1:0] disp_addr_o
);

  logic [ADDR_W-1:0] row_base_q;
  logic [ADDR_W-1:0] row_base_d;
  logic [ADDR_W-1:0] rbn_s;
  logic [ADDR_W-1:0] col_addr_s;
  logic [10:0]       yn_s;
  logic              slot_a_s;
  logic              slot_b_s;
  logic              eol_s;

  // Slot decode; the row base steps by one text row every 8 lines, so no multiplier
  always_comb begin
    yn_s  = (y_i == 11'(V_TOTAL - 1)) ? 11'd0 : y_i + 11'd1;
    eol_s = (x_i == 11'(H_TOTAL - 2));
    if (yn_s == 11'd0) begin
      rbn_s = {ADDR_W{1'b0}};
    end else if (yn_s[2:0] == 3'd0) begin
      rbn_s = row_base_q + ADDR_W'(COLS);
    end else begin
      rbn_s = row_base_q;
    end
    col_addr_s = row_base_q + ADDR_W'(x_i >> 3) + ADDR_W'(1);
    slot_a_s   = (y_i < 11'(V_ACTIVE)) && (x_i < 11'(H_ACTIVE - 8)) && (x_i[2:0] == 3'd6);
    slot_b_s   = eol_s && (yn_s < 11'(V_ACTIVE));
    row_base_d = eol_s ? rbn_s : row_base_q;
  end

  assign disp_slot_o = slot_a_s || slot_b_s;
  assign disp_addr_o = slot_b_s ? rbn_s : col_addr_s;

  // Row base register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_base_q <= {ADDR_W{1'b0}};
    end else begin
      row_base_q <= row_base_d;
    end
  end

endmodule

// File: rtl/text_scheduler.sv
// Text RAM scheduler: display fetch has fixed priority slots, the clear engine and host
// writes share the remaining cycles; fetched cells are presented aligned with the pixel.
module text_scheduler
  import text_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [10:0]       i_x,
  input  logic [10:0]       i_y,
  text_scheduler_if.slave   host,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [7:0]        o_ram_wdata,
  input  logic [7:0]        i_ram_rdata,
  output logic [5:0]        o_char,
  output logic [1:0]        o_color
);

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        fill_q;
  logic [7:0]        fill_d;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [ADDR_W-1:0] clr_addr_d;
  cell_t             cell_q;
  cell_t             cell_d;
  logic              load_q;
  logic              disp_slot_s;
  logic [ADDR_W-1:0] disp_addr_s;
  logic              busy_s;
  logic              host_in_range_s;

  text_slot_gen u_slot_gen (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .x_i         (i_x),
    .y_i         (i_y),
    .disp_slot_o (disp_slot_s),
    .disp_addr_o (disp_addr_s)
  );

  assign busy_s          = (state_q == S_CLEAR);
  assign host_in_range_s = (host.i_wr_addr < ADDR_W'(CELLS));
  assign host.o_busy     = busy_s;
  assign host.o_wr_ready = !busy_s && !disp_slot_s;

  // Clear FSM next state: one fill write per free cycle, a new i_clr is ignored while busy
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_IDLE: begin
        if (host.i_clr) begin
          state_d    = S_CLEAR;
          fill_d     = host.i_clr_data;
          clr_addr_d = {ADDR_W{1'b0}};
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (disp_slot_s) begin
          clr_addr_d = clr_addr_q;
        end else if (clr_addr_q == LAST_CELL) begin
          state_d    = S_IDLE;
          clr_addr_d = {ADDR_W{1'b0}};
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        clr_addr_d = {ADDR_W{1'b0}};
      end
    endcase
  end

  // RAM port mux; writes are suppressed while reset is asserted
  always_comb begin
    o_ram_addr  = host.i_wr_addr;
    o_ram_we    = 1'b0;
    o_ram_wdata = host.i_wr_data;
    if (disp_slot_s) begin
      o_ram_addr  = disp_addr_s;
      o_ram_wdata = 8'd0;
    end else if (busy_s) begin
      o_ram_addr  = clr_addr_q;
      o_ram_we    = !i_rst;
      o_ram_wdata = fill_q;
    end else begin
      o_ram_we    = host.i_wr_valid && host_in_range_s && !i_rst;
    end
  end

  // Cell output: load the read data the cycle after a fetch, blank after the visible area
  always_comb begin
    cell_d = cell_q;
    if (load_q) begin
      cell_d = cell_t'(i_ram_rdata);
    end else if (i_x == 11'(H_ACTIVE - 1)) begin
      cell_d = CELL_BLANK;
    end else begin
      cell_d = cell_q;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      fill_q     <= 8'd0;
      clr_addr_q <= {ADDR_W{1'b0}};
      cell_q     <= CELL_BLANK;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      clr_addr_q <= clr_addr_d;
      cell_q     <= cell_d;
      load_q     <= disp_slot_s;
    end
  end

  assign o_char  = cell_q.glyph;
  assign o_color = cell_q.color;

endmodule

// File: tb/tb_text_scheduler.sv
// Directed bench for text_scheduler: vector table for the first text row plus
// sequences for row advance, vertical blanking, clear and reset during a clear.
module tb_text_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] x;
  logic [10:0] y;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [5:0]  ch;
  logic [1:0]  col;

  logic        bd_we;
  logic [12:0] bd_addr;
  logic [7:0]  bd_data;
  logic [7:0]  mem [0:8191];

  int n_cmp = 0;
  int n_err = 0;

  text_scheduler_if hif();

  text_scheduler dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_x         (x),
    .i_y         (y),
    .host        (hif),
    .o_ram_addr  (ram_addr),
    .o_ram_we    (ram_we),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata),
    .o_char      (ch),
    .o_color     (col)
  );

  always #5 clk = ~clk;

  // External single-port RAM with a bench-only preload port
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    int x, y, wv, wa, wd;
    int cc, ch, col;
    int rdy, we;
    int ca, addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int vx, int vy, int wv, int wa, int wd, int cc, int vch,
                              int vcol, int rdy, int we, int ca, int addr);
    vec_t v;
    v.x = vx; v.y = vy; v.wv = wv; v.wa = wa; v.wd = wd;
    v.cc = cc; v.ch = vch; v.col = vcol; v.rdy = rdy; v.we = we; v.ca = ca; v.addr = addr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (x=%0d y=%0d t=%0t)", nm, act, exp, x, y, $time);
    end
  endtask

  task automatic adv_to(input int nx, input int ny);
    @(posedge clk);
    #1;
    x = 11'(nx);
    y = 11'(ny);
  endtask

  task automatic adv();
    int nx;
    int ny;
    nx = int'(x) + 1;
    ny = int'(y);
    if (nx == 800) begin
      nx = 0;
      ny = (ny == 524) ? 0 : ny + 1;
    end
    adv_to(nx, ny);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xi, yi, yn, rb, ea, nwr, bad, rviol, last_w, done, badc;
    logic slot;

    rst = 1'b1; x = 11'd0; y = 11'd0;
    bd_we = 1'b0; bd_addr = 13'd0; bd_data = 8'd0;
    hif.i_wr_valid = 1'b0; hif.i_wr_addr = 13'd0; hif.i_wr_data = 8'd0;
    hif.i_clr = 1'b0; hif.i_clr_data = 8'd0;

    // Table for the first text row: prefetch on the last frame line, cell loads, blanking
    tbl.push_back(mk(798, 524, 0, 0,    0,     1, 0,     3, 0, 0, 1, 0));
    tbl.push_back(mk(799, 524, 1, 5000, 8'h55, 1, 0,     3, 1, 0, 0, 0));
    tbl.push_back(mk(0,   0,   1, 100,  8'h77, 1, 5,     2, 1, 1, 1, 100));
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(i, 0, 0, 0, 0, 1, 5, 2, 1, 0, 0, 0));
    tbl.push_back(mk(6,   0,   1, 101,  8'h66, 1, 5,     2, 0, 0, 1, 1));
    tbl.push_back(mk(7,   0,   0, 0,    0,     1, 5,     2, 1, 0, 0, 0));
    for (int i = 8; i <= 13; i++) tbl.push_back(mk(i, 0, 0, 0, 0, 1, 6'h2A, 0, 1, 0, 0, 0));
    tbl.push_back(mk(14,  0,   0, 0,    0,     1, 6'h2A, 0, 0, 0, 1, 2));
    tbl.push_back(mk(15,  0,   0, 0,    0,     1, 6'h2A, 0, 1, 0, 0, 0));
    tbl.push_back(mk(639, 0,   0, 0,    0,     0, 0,     0, 1, 0, 0, 0));
    tbl.push_back(mk(640, 0,   0, 0,    0,     1, 0,     3, 1, 0, 0, 0));
    tbl.push_back(mk(641, 0,   0, 0,    0,     1, 0,     3, 1, 0, 0, 0));
    tbl.push_back(mk(700, 0,   0, 0,    0,     1, 0,     3, 1, 0, 0, 0));
    tbl.push_back(mk(797, 0,   0, 0,    0,     1, 0,     3, 1, 0, 0, 0));

    // Reset with RAM preload of the first cells
    adv_to(0, 0); bd_we = 1'b1; bd_addr = 13'd0; bd_data = 8'h85;
    adv_to(0, 0); bd_addr = 13'd1; bd_data = 8'h2A;
    adv_to(0, 0); bd_addr = 13'd2; bd_data = 8'h00;
    adv_to(0, 0); bd_we = 1'b0;
    #2;
    chk("reset char", 32'(ch), 32'd0);
    chk("reset color", 32'(col), 32'd3);
    chk("reset busy", 32'(hif.o_busy), 32'd0);
    chk("reset we", 32'(ram_we), 32'd0);

    foreach (tbl[i]) begin
      adv_to(tbl[i].x, tbl[i].y);
      rst = 1'b0;
      hif.i_wr_valid = tbl[i].wv[0];
      hif.i_wr_addr  = 13'(tbl[i].wa);
      hif.i_wr_data  = 8'(tbl[i].wd);
      #2;
      if (tbl[i].cc != 0) begin
        chk($sformatf("vec%0d char", i), 32'(ch), tbl[i].ch);
        chk($sformatf("vec%0d color", i), 32'(col), tbl[i].col);
      end
      chk($sformatf("vec%0d ready", i), 32'(hif.o_wr_ready), tbl[i].rdy);
      chk($sformatf("vec%0d we", i), 32'(ram_we), tbl[i].we);
      if (tbl[i].ca != 0) chk($sformatf("vec%0d addr", i), 32'(ram_addr), tbl[i].addr);
    end

    // Full lines 1..7 with the host writing every cycle; row advance at y=7->8
    hif.i_wr_valid = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      adv();
      hif.i_wr_addr = 13'd2000 + 13'(x);
      hif.i_wr_data = x[7:0];
      #2;
      xi = int'(x); yi = int'(y);
      yn = (yi == 524) ? 0 : yi + 1;
      rb = (yi >= 8) ? 80 : 0;
      slot = (yi < 480 && xi < 632 && xi % 8 == 6) || (xi == 798 && yn < 480);
      if (xi == 798) ea = (yn % 8 == 0) ? rb + 80 : rb;
      else ea = rb + xi / 8 + 1;
      chk("line ready", 32'(hif.o_wr_ready), 32'(!slot));
      if (slot) chk("line addr", 32'(ram_addr), 32'(ea));
      else chk("line we", 32'(ram_we), 32'd1);
      if (yi == 8 && xi == 7) break;
    end
    chk("line end reached", 32'(y), 32'd8);
    hif.i_wr_valid = 1'b0;

    // Lines 8..15 around the end-of-line prefetch only
    for (int yy = 8; yy <= 15; yy++) begin
      for (int xx = 796; xx <= 799; xx++) begin
        adv_to(xx, yy);
        #2;
        if (xx == 798) begin
          chk("row prefetch ready", 32'(hif.o_wr_ready), 32'd0);
          chk("row prefetch addr", 32'(ram_addr), (yy == 15) ? 32'd160 : 32'd80);
        end
      end
    end

    // Vertical blanking lines never fetch, except the prefetch for line 0
    for (int yy = 480; yy <= 524; yy++) begin
      adv_to(6, yy);
      #2;
      chk("vblank x6 ready", 32'(hif.o_wr_ready), 32'd1);
      adv_to(798, yy);
      #2;
      chk("vblank x798 ready", 32'(hif.o_wr_ready), (yy == 524) ? 32'd0 : 32'd1);
      if (yy == 524) chk("frame prefetch addr", 32'(ram_addr), 32'd0);
    end

    // Clear with a simultaneous host write, a second i_clr mid-way, host held valid
    adv_to(1, 0);
    hif.i_clr = 1'b1; hif.i_clr_data = 8'h3F;
    hif.i_wr_valid = 1'b1; hif.i_wr_addr = 13'd10; hif.i_wr_data = 8'h99;
    #2;
    chk("clr start ready", 32'(hif.o_wr_ready), 32'd1);
    chk("clr start we", 32'(ram_we), 32'd1);
    chk("clr start addr", 32'(ram_addr), 32'd10);
    chk("clr start busy", 32'(hif.o_busy), 32'd0);
    nwr = 0; bad = 0; rviol = 0; last_w = -1; done = -1;
    for (int k = 0; k < 20000; k++) begin
      adv();
      hif.i_clr = (k == 1000);
      hif.i_clr_data = (k == 1000) ? 8'h00 : 8'h3F;
      hif.i_wr_valid = (k < 2000);
      hif.i_wr_addr = 13'd20; hif.i_wr_data = 8'hAA;
      #2;
      if (!hif.o_busy) begin
        done = k;
        break;
      end
      if (hif.o_wr_ready) rviol++;
      if (ram_we) begin
        if (int'(ram_addr) != nwr || ram_wdata != 8'h3F) bad++;
        nwr++;
        last_w = k;
      end
    end
    hif.i_clr = 1'b0; hif.i_wr_valid = 1'b0;
    chk("clr write count", 32'(nwr), 32'd4800);
    chk("clr write sequence errors", 32'(bad), 32'd0);
    chk("clr ready while busy", 32'(rviol), 32'd0);
    chk("clr busy drop cycle", 32'(done), 32'(last_w + 1));
    badc = 0;
    for (int a = 0; a < 4800; a++) if (mem[a] !== 8'h3F) badc++;
    chk("clr cells not 3F", 32'(badc), 32'd0);

    // Reset after 100 clear writes
    adv();
    hif.i_clr = 1'b1; hif.i_clr_data = 8'h11;
    #2;
    nwr = 0;
    for (int k = 0; k < 3000; k++) begin
      adv();
      hif.i_clr = 1'b0;
      #2;
      if (ram_we) nwr++;
      if (nwr == 100) break;
    end
    chk("rst clear writes seen", 32'(nwr), 32'd100);
    adv();
    rst = 1'b1;
    #2;
    chk("rst cycle we", 32'(ram_we), 32'd0);
    adv();
    rst = 1'b0;
    #2;
    chk("post-rst busy", 32'(hif.o_busy), 32'd0);
    chk("post-rst we", 32'(ram_we), 32'd0);
    chk("post-rst char", 32'(ch), 32'd0);
    chk("post-rst color", 32'(col), 32'd3);
    for (int k = 0; k < 20; k++) adv();
    #2;
    badc = 0;
    for (int a = 0; a < 100; a++) if (mem[a] !== 8'h11) badc++;
    chk("rst cells 0..99 not 11", 32'(badc), 32'd0);
    badc = 0;
    for (int a = 100; a < 4800; a++) if (mem[a] !== 8'h3F) badc++;
    chk("rst cells 100+ changed", 32'(badc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
